// File: rtl/game_pkg.sv
// Shared definitions for the tile line-merge datapath.
//
// Contents:
//   DEF_N_CELLS : default number of cells in one line
//   DEF_VAL_W   : default tile exponent width (0 = empty cell)
//   DEF_SCORE_W : default score accumulator width
//   state_t     : merge-pass controller states
package game_pkg;

    localparam int DEF_N_CELLS = 4;
    localparam int DEF_VAL_W   = 4;
    localparam int DEF_SCORE_W = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/tile_score.sv
// Converts a tile exponent e into the score earned by merging two such tiles,
// i.e. the value of the resulting tile 2^(e+1). When that value does not fit
// in SCORE_W bits, the result saturates to all ones.
//
// Ports:
//   exp_val : input  tile exponent
//   value   : output 2^(exp_val+1), saturated to SCORE_W bits
module tile_score #(
    parameter int VAL_W   = 4,
    parameter int SCORE_W = 20
) (
    input  logic [VAL_W-1:0]   exp_val,
    output logic [SCORE_W-1:0] value
);

    logic [VAL_W:0] shamt;

    assign shamt = {1'b0, exp_val} + {{VAL_W{1'b0}}, 1'b1};

    // A shift of SCORE_W or more would lose the single set bit, so that case
    // is replaced by the saturated maximum.
    always_comb begin
        value = '0;
        if (int'(shamt) >= SCORE_W) begin
            value = '1;
        end else begin
            value = {{(SCORE_W-1){1'b0}}, 1'b1} << shamt;
        end
    end

endmodule

// File: rtl/line_merge_unit.sv
// Multi-cycle slide-and-merge engine for one line of a 2048-style board.
// A pass compacts nonzero tiles towards cell 0, merging equal neighbours once
// each, and reports the resulting line, whether anything moved, how many
// merges happened and the score they earned.
//
// Ports:
//   clk       : input  clock
//   rst       : input  asynchronous active-high reset
//   start     : input  request a pass (only honoured while idle)
//   line_in   : input  line to merge, cell 0 in the low bits
//   busy      : output pass in progress (SCAN, FLUSH, DONE)
//   done      : output one-cycle pulse, results valid
//   line_out  : output merged line, same packing as line_in
//   moved     : output merged line differs from the captured input
//   merge_cnt : output merges performed in the last pass
//   score     : output score earned in the last pass (saturating)
module line_merge_unit
    import game_pkg::*;
#(
    parameter int N_CELLS = DEF_N_CELLS,
    parameter int VAL_W   = DEF_VAL_W,
    parameter int SCORE_W = DEF_SCORE_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [N_CELLS*VAL_W-1:0]   line_in,
    output logic                       busy,
    output logic                       done,
    output logic [N_CELLS*VAL_W-1:0]   line_out,
    output logic                       moved,
    output logic [$clog2(N_CELLS):0]   merge_cnt,
    output logic [SCORE_W-1:0]         score
);

    localparam int IDX_W = $clog2(N_CELLS);
    localparam int CNT_W = $clog2(N_CELLS) + 1;
    localparam logic [VAL_W-1:0] MAX_EXP  = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CELLS - 1);

    state_t state;
    state_t state_nxt;

    logic [VAL_W-1:0]   cap  [N_CELLS];
    logic [VAL_W-1:0]   work [N_CELLS];
    logic [VAL_W-1:0]   fin  [N_CELLS];
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   wptr;
    logic [VAL_W-1:0]   pend;
    logic               pend_v;
    logic [CNT_W-1:0]   mcnt;
    logic [SCORE_W-1:0] acc;

    logic [VAL_W-1:0]   cur;
    logic               do_merge;
    logic               do_push;
    logic [SCORE_W-1:0] merge_pts;
    logic [SCORE_W:0]   acc_sum;
    logic [SCORE_W-1:0] acc_next;

    logic [N_CELLS*VAL_W-1:0] cap_flat;
    logic [N_CELLS*VAL_W-1:0] fin_flat;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: SCAN lasts one cycle per cell, then a single FLUSH
    // and a single DONE cycle before start is looked at again.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (idx == LAST_IDX) state_nxt = FLUSH;
            FLUSH:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Per-cell decision. A merge consumes the pending tile, so the merged
    // result can never be the pending tile of a later merge in this pass.
    // Saturated tiles are excluded from merging.
    always_comb begin
        cur      = cap[idx];
        do_merge = (cur != '0) && pend_v && (pend == cur) && (cur != MAX_EXP);
        do_push  = (cur != '0) && pend_v && !do_merge;
    end

    tile_score #(
        .VAL_W   (VAL_W),
        .SCORE_W (SCORE_W)
    ) u_tile_score (
        .exp_val (cur),
        .value   (merge_pts)
    );

    // Saturating accumulation of the score for the current pass.
    always_comb begin
        acc_sum  = {1'b0, acc} + {1'b0, merge_pts};
        acc_next = acc_sum[SCORE_W] ? '1 : acc_sum[SCORE_W-1:0];
    end

    // Final line: the work buffer with any still-pending tile dropped at the
    // write pointer. Cells above it were cleared at start and stay zero.
    always_comb begin
        for (int i = 0; i < N_CELLS; i++) begin
            fin[i] = work[i];
        end
        if (pend_v) begin
            fin[wptr] = pend;
        end
        cap_flat = '0;
        fin_flat = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            cap_flat[i*VAL_W +: VAL_W] = cap[i];
            fin_flat[i*VAL_W +: VAL_W] = fin[i];
        end
    end

    // Datapath: capture on start, one cell per SCAN cycle, publish all
    // results together when leaving FLUSH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CELLS; i++) begin
                cap[i]  <= '0;
                work[i] <= '0;
            end
            idx       <= '0;
            wptr      <= '0;
            pend      <= '0;
            pend_v    <= 1'b0;
            mcnt      <= '0;
            acc       <= '0;
            line_out  <= '0;
            moved     <= 1'b0;
            merge_cnt <= '0;
            score     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N_CELLS; i++) begin
                            cap[i]  <= line_in[i*VAL_W +: VAL_W];
                            work[i] <= '0;
                        end
                        idx    <= '0;
                        wptr   <= '0;
                        pend   <= '0;
                        pend_v <= 1'b0;
                        mcnt   <= '0;
                        acc    <= '0;
                    end
                end
                SCAN: begin
                    idx <= idx + IDX_W'(1);
                    if (do_merge) begin
                        work[wptr] <= cur + VAL_W'(1);
                        wptr       <= wptr + IDX_W'(1);
                        pend_v     <= 1'b0;
                        mcnt       <= mcnt + CNT_W'(1);
                        acc        <= acc_next;
                    end else if (do_push) begin
                        work[wptr] <= pend;
                        wptr       <= wptr + IDX_W'(1);
                        pend       <= cur;
                    end else if (cur != '0) begin
                        pend   <= cur;
                        pend_v <= 1'b1;
                    end
                end
                FLUSH: begin
                    line_out  <= fin_flat;
                    moved     <= (fin_flat != cap_flat);
                    merge_cnt <= mcnt;
                    score     <= acc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_merge_unit.sv
// Directed self-checking bench for line_merge_unit at default parameters.
module tb_line_merge_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] line_in;
    logic        busy;
    logic        done;
    logic [15:0] line_out;
    logic        moved;
    logic [2:0]  merge_cnt;
    logic [19:0] score;

    int checks_total;
    int checks_passed;

    line_merge_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .line_in   (line_in),
        .busy      (busy),
        .done      (done),
        .line_out  (line_out),
        .moved     (moved),
        .merge_cnt (merge_cnt),
        .score     (score)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Packs four cells, cell 0 first, into the line bus layout.
    function automatic logic [15:0] pack(input int c0, input int c1, input int c2, input int c3);
        logic [15:0] v;
        v = {c3[3:0], c2[3:0], c1[3:0], c0[3:0]};
        return v;
    endfunction

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end else begin
            checks_passed++;
        end
    endtask

    // Runs one full pass on the given line and checks its timing. With poke
    // set, start is also pulsed during SCAN and DONE to show it is ignored.
    task automatic applyStimulus(input string tag, input logic [15:0] line, input bit poke);
        int lat;
        @(negedge clk);
        line_in = line;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput({tag, ".busy_after_accept"}, 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (poke && lat == 1) start = 1'b1;
            if (poke && lat == 2) start = 1'b0;
        end
        checkOutput({tag, ".done_latency"}, 32'(lat), 32'd5);
        if (poke) start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput({tag, ".done_one_cycle"}, 32'(done), 32'd0);
        checkOutput({tag, ".idle_after_done"}, 32'(busy), 32'd0);
        if (poke) begin
            @(posedge clk);
            #1;
            checkOutput({tag, ".poke_ignored"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int ndone;
        int cyc;
        int tdone [3];

        checks_total  = 0;
        checks_passed = 0;
        rst     = 1'b1;
        start   = 1'b0;
        line_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.done", 32'(done), 32'd0);
        checkOutput("reset.line_out", 32'(line_out), 32'd0);
        checkOutput("reset.score", 32'(score), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] scenario 1: pairs merge once each");
        applyStimulus("s1", pack(1, 1, 1, 1), 1'b1);
        checkOutput("s1.line_out", 32'(line_out), 32'(pack(2, 2, 0, 0)));
        checkOutput("s1.merge_cnt", 32'(merge_cnt), 32'd2);
        checkOutput("s1.score", 32'(score), 32'd8);
        checkOutput("s1.moved", 32'(moved), 32'd1);

        $display("[TB] scenario 2: gap skipped before merge");
        applyStimulus("s2", pack(2, 0, 2, 3), 1'b0);
        checkOutput("s2.line_out", 32'(line_out), 32'(pack(3, 3, 0, 0)));
        checkOutput("s2.merge_cnt", 32'(merge_cnt), 32'd1);
        checkOutput("s2.score", 32'(score), 32'd8);
        checkOutput("s2.moved", 32'(moved), 32'd1);

        $display("[TB] scenario 3: nothing to do, and saturated tiles");
        applyStimulus("s3a", pack(1, 2, 3, 4), 1'b0);
        checkOutput("s3a.line_out", 32'(line_out), 32'(pack(1, 2, 3, 4)));
        checkOutput("s3a.merge_cnt", 32'(merge_cnt), 32'd0);
        checkOutput("s3a.score", 32'(score), 32'd0);
        checkOutput("s3a.moved", 32'(moved), 32'd0);
        applyStimulus("s3b", pack(15, 15, 0, 0), 1'b0);
        checkOutput("s3b.line_out", 32'(line_out), 32'(pack(15, 15, 0, 0)));
        checkOutput("s3b.merge_cnt", 32'(merge_cnt), 32'd0);
        checkOutput("s3b.score", 32'(score), 32'd0);
        checkOutput("s3b.moved", 32'(moved), 32'd0);

        $display("[TB] scenario 4: slide only, then no double merge");
        applyStimulus("s4a", pack(0, 0, 0, 5), 1'b0);
        checkOutput("s4a.line_out", 32'(line_out), 32'(pack(5, 0, 0, 0)));
        checkOutput("s4a.moved", 32'(moved), 32'd1);
        checkOutput("s4a.merge_cnt", 32'(merge_cnt), 32'd0);
        applyStimulus("s4b", pack(1, 1, 2, 0), 1'b0);
        checkOutput("s4b.line_out", 32'(line_out), 32'(pack(2, 2, 0, 0)));
        checkOutput("s4b.merge_cnt", 32'(merge_cnt), 32'd1);
        checkOutput("s4b.score", 32'(score), 32'd4);

        $display("[TB] scenario 5: reset during SCAN");
        @(negedge clk);
        line_in = pack(1, 1, 1, 1);
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("s5.rst_busy", 32'(busy), 32'd0);
        checkOutput("s5.rst_line_out", 32'(line_out), 32'd0);
        checkOutput("s5.rst_merge_cnt", 32'(merge_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus("s5", pack(3, 3, 0, 0), 1'b0);
        checkOutput("s5.line_out", 32'(line_out), 32'(pack(4, 0, 0, 0)));
        checkOutput("s5.score", 32'(score), 32'd16);
        checkOutput("s5.merge_cnt", 32'(merge_cnt), 32'd1);

        $display("[TB] scenario 6: start held high for back-to-back passes");
        @(negedge clk);
        line_in = pack(1, 1, 1, 1);
        start   = 1'b1;
        ndone   = 0;
        cyc     = 0;
        while (ndone < 3 && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 3) line_in = pack(7, 7, 7, 7);
            if (done) begin
                tdone[ndone] = cyc;
                if (ndone == 0) begin
                    checkOutput("s6.pass1_line_out", 32'(line_out), 32'(pack(2, 2, 0, 0)));
                end else if (ndone == 1) begin
                    checkOutput("s6.pass2_line_out", 32'(line_out), 32'(pack(8, 8, 0, 0)));
                    checkOutput("s6.pass2_score", 32'(score), 32'd512);
                end
                ndone++;
            end
        end
        start = 1'b0;
        checkOutput("s6.done_count", 32'(ndone), 32'd3);
        if (ndone == 3) begin
            checkOutput("s6.first_done", 32'(tdone[0]), 32'd6);
            checkOutput("s6.spacing_1_2", 32'(tdone[1] - tdone[0]), 32'd7);
            checkOutput("s6.spacing_2_3", 32'(tdone[2] - tdone[1]), 32'd7);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/line_merge_unit.md
LINE_MERGE_UNIT -- requirements
Module: line_merge_unit

Interface
REQ-001 The module SHALL have parameter N_CELLS, default 4, giving the number of cells in one line (legal range 2..16).
REQ-002 The module SHALL have parameter VAL_W, default 4, giving the tile exponent width (0 = empty, e = tile value 2^e).
REQ-003 The module SHALL have parameter SCORE_W, default 20, giving the score accumulator width.
REQ-004 The module SHALL have one clock; reset is asynchronous and active-high.
REQ-005 The module SHALL have the following ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  asynchronous active-high reset.
start  in  1  request a merge pass; sampled only in IDLE.
line_in  in  N_CELLS*VAL_W  input line; cell 0 = bits [VAL_W-1:0]; cell 0 is the slide destination.
busy  out  1  high in SCAN, FLUSH and DONE.
done  out  1  one-cycle pulse; outputs are valid.
line_out  out  N_CELLS*VAL_W  compacted and merged line, same packing as line_in.
moved  out  1  line_out differs from the captured line_in.
merge_cnt  out  $clog2(N_CELLS)+1  number of merges in the last pass.
score  out  SCORE_W  sum of 2^(e+1) over every merge of two tiles of exponent e, for the last pass.

Function
REQ-006 The FSM SHALL have states IDLE, SCAN, FLUSH and DONE.
REQ-007 FSM transitions SHALL be:
- IDLE -> SCAN when start=1;
- SCAN -> FLUSH after N_CELLS cycles;
- FLUSH -> DONE;
- DONE -> IDLE unconditionally.
REQ-008 On the edge that accepts start, the block SHALL capture line_in into an internal copy and clear the read index, write pointer, pending-valid flag, merge count and score working registers; line_in is ignored after that edge.
REQ-009 start SHALL be ignored while busy=1, including in DONE; no queuing.
REQ-010 SCAN SHALL examine one captured cell per cycle, index 0 to N_CELLS-1; a zero cell is skipped.
REQ-011 For a nonzero cell t in SCAN:
- if pending is valid, pending==t and t != 2^VAL_W-1: write t+1 at the write pointer, increment the pointer, invalidate pending, increment merge count, and add 2^(t+1) to score;
- else if pending is valid: write pending at the write pointer, increment the pointer, and set pending=t;
- else: set pending=t (valid).
REQ-012 A merged result SHALL NOT merge again in the same pass (for example [1,1,2] -> [2,2], never [3]).
REQ-013 Tiles at maximum exponent 2^VAL_W-1 SHALL never merge (saturation); they compact only.
REQ-014 FLUSH SHALL write a valid pending tile at the write pointer; all cells at or above the final write pointer SHALL be 0.
REQ-015 line_out, moved, merge_cnt and score SHALL update together on the FLUSH->DONE edge and hold until the next pass's FLUSH->DONE edge.
REQ-016 done SHALL be high for exactly one cycle, N_CELLS+1 rising edges after the edge that accepted start.
REQ-017 With start held continuously high, passes SHALL start every N_CELLS+3 cycles.
REQ-018 score accumulation SHALL saturate at 2^SCORE_W-1; merge_cnt SHALL never wrap (maximum N_CELLS/2).
REQ-019 moved SHALL equal (line_out != captured line_in) and SHALL be 0 for an all-zero line.

Reset
REQ-020 rst=1 SHALL, asynchronously, force state to IDLE and set busy=0, done=0, line_out=0, moved=0, merge_cnt=0 and score=0, together with all working registers.
REQ-021 Reset asserted mid-pass SHALL abort the pass with no partial outputs; the first start accepted after rst is deasserted SHALL run a complete normal pass.

Structure
REQ-022 The FSM state encoding and the default N_CELLS, VAL_W and SCORE_W constants SHALL live in shared package game_pkg.
REQ-023 The exponent-to-score conversion (e -> 2^(e+1), zero-extended or saturated to SCORE_W) SHALL be a separate combinational sub-module named tile_score.

Verification
All scenarios use default parameters; lines are listed cell0 first.
REQ-024 Bench scenario 1: line_in=[1,1,1,1], start pulse -> line_out=[2,2,0,0], merge_cnt=2, score=8, moved=1, done exactly 5 edges after the accepting edge.
REQ-025 Bench scenario 2: [2,0,2,3] -> [3,3,0,0], merge_cnt=1, score=8, moved=1.
REQ-026 Bench scenario 3: [1,2,3,4] -> [1,2,3,4], merge_cnt=0, score=0, moved=0; and [15,15,0,0] -> [15,15,0,0], merge_cnt=0 (saturation).
REQ-027 Bench scenario 4: [0,0,0,5] -> [5,0,0,0], moved=1; then [1,1,2,0] -> [2,2,0,0], merge_cnt=1 (no double merge).
REQ-028 Bench scenario 5: rst pulsed 2 cycles into SCAN -> busy=0 and line_out=0 immediately; the next start with [3,3,0,0] -> [4,0,0,0], score=16.
REQ-029 Bench scenario 6: start held high for 3 passes -> done pulses exactly 7 cycles apart; start pulses issued during busy are ignored, and line_in changed during SCAN does not affect the result.
